// File: rtl/fxp_pkg.sv
// Shared fixed-point arithmetic types and helpers.
// Used by the iterative divider and multiplier control.
package fxp_pkg;

    localparam int W_MAX = 128;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fxp_state_e;

    // Two's-complement negate when neg is set; callers truncate to their width.
    function automatic logic [W_MAX-1:0] cond_neg(
        input logic [W_MAX-1:0] v,
        input logic             neg
    );
        return neg ? (~v + W_MAX'(1)) : v;
    endfunction

endpackage

// File: rtl/fxp_iter_div_datapath.sv
// Restoring-division datapath: remainder, dividend, quotient and result mux.
// Define FXP_DIV_SATURATE_EN to saturate overflowing quotients.
module fxp_iter_div_datapath
    import fxp_pkg::*;
#(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int sign = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         finish,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] c
);

    localparam int W = n + d;
    localparam logic [n-1:0] MAX_POS = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};
    localparam logic [n-1:0] ONES    = '1;

    logic [W-1:0] dvd;
    logic [W-1:0] quo;
    logic [n-1:0] dvs;
    logic [n:0]   rem;
    logic         neg;
    logic         a_neg;
    logic         b_zero;

    logic [n-1:0] a_mag;
    logic [n-1:0] b_mag;
    logic [n+1:0] rem_sh;
    logic [n+1:0] diff;
    logic         ge;
    logic [W-1:0] quo_nx;
    logic [n-1:0] q_wrap;
    logic [n-1:0] res;
`ifdef FXP_DIV_SATURATE_EN
    logic         ovf;
`endif

    always_comb begin
        a_mag  = n'(cond_neg(W_MAX'(a), (sign != 0) && a[n-1]));
        b_mag  = n'(cond_neg(W_MAX'(b), (sign != 0) && b[n-1]));
        rem_sh = {rem, dvd[W-1]};
        ge     = rem_sh >= {2'b00, dvs};
        diff   = rem_sh - {2'b00, dvs};
        quo_nx = {quo[W-2:0], ge};
        // Negating the low n bits equals truncating the negated full quotient.
        q_wrap = n'(cond_neg(W_MAX'(quo_nx), neg));
        res    = q_wrap;
`ifdef FXP_DIV_SATURATE_EN
        if (sign != 0)
            ovf = neg ? (quo_nx > W'(MIN_NEG)) : (quo_nx >= W'(MIN_NEG));
        else
            ovf = quo_nx > W'(ONES);
        if (ovf)
            res = (sign != 0) ? (neg ? MIN_NEG : MAX_POS) : ONES;
`endif
        if (b_zero)
            res = (sign != 0) ? (a_neg ? MIN_NEG : MAX_POS) : ONES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd    <= '0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            neg    <= 1'b0;
            a_neg  <= 1'b0;
            b_zero <= 1'b0;
            c      <= '0;
        end else if (load) begin
            dvd    <= W'(a_mag) << d;
            quo    <= '0;
            dvs    <= b_mag;
            rem    <= '0;
            neg    <= (sign != 0) && (a[n-1] ^ b[n-1]);
            a_neg  <= (sign != 0) && a[n-1];
            b_zero <= (b == '0);
        end else if (step) begin
            dvd <= dvd << 1;
            quo <= quo_nx;
            rem <= ge ? (n+1)'(diff) : (n+1)'(rem_sh);
            if (finish)
                c <= res;
        end
    end

endmodule

// File: rtl/fixed_point_iterative_divider.sv
// Unpipelined fixed-point restoring divider, one quotient bit per cycle.
// Define FXP_DIV_SATURATE_EN to saturate on overflow instead of wrapping.
module fixed_point_iterative_divider
    import fxp_pkg::*;
#(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int sign = 1
) (
    input  logic         clk,
    input  logic         reset,
    output logic         recv_rdy,
    input  logic         recv_val,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         send_rdy,
    output logic         send_val,
    output logic [n-1:0] c
);

    localparam int CW = $clog2(n + d);
    localparam logic [CW-1:0] LAST = CW'(n + d - 1);

    fxp_state_e    state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          finish;

    assign load   = (state == IDLE) && recv_val;
    assign step   = (state == CALC);
    assign finish = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (recv_val) begin
                        state    <= CALC;
                        cnt      <= '0;
                        recv_rdy <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        cnt      <= '0;
                        send_val <= 1'b1;
                    end
                end
                DONE: begin
                    if (send_rdy) begin
                        state    <= IDLE;
                        send_val <= 1'b0;
                        recv_rdy <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    recv_rdy <= 1'b1;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

    fxp_iter_div_datapath #(
        .n    (n),
        .d    (d),
        .sign (sign)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .finish (finish),
        .a      (a),
        .b      (b),
        .c      (c)
    );

endmodule

// File: tb/tb_fixed_point_iterative_divider.sv
// Directed and random checks of the Q4.4 signed divider against
// an integer-arithmetic reference model.
module tb_fixed_point_iterative_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       recv_rdy;
    logic       recv_val;
    logic [7:0] a;
    logic [7:0] b;
    logic       send_rdy;
    logic       send_val;
    logic [7:0] c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_point_iterative_divider #(
        .n    (8),
        .d    (4),
        .sign (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_rdy (recv_rdy),
        .recv_val (recv_val),
        .a        (a),
        .b        (b),
        .send_rdy (send_rdy),
        .send_val (send_val),
        .c        (c)
    );

    // Q = trunc((a * 2^4) / b) on signed values, then wrap or saturate.
    function automatic logic [7:0] ref_div(logic [7:0] x, logic [7:0] y);
        longint xi = longint'($signed(x));
        longint yi = longint'($signed(y));
        longint q;
        if (yi == 0)
            return (xi < 0) ? 8'h80 : 8'h7F;
        q = (xi * 16) / yi;
`ifdef FXP_DIV_SATURATE_EN
        if (q > 127)  return 8'h7F;
        if (q < -128) return 8'h80;
`endif
        return q[7:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, optional busy-time disturbances, backpressure.
    task automatic run(input logic [7:0] x, input logic [7:0] y,
                       input int hold, input bit poke, string tag);
        int lat;
        int wt;
        logic [7:0] exp;
        exp = ref_div(x, y);
        wt  = 0;
        while (!recv_rdy && wt < 50) begin
            @(posedge clk); #1;
            wt++;
        end
        check({tag, "_rdy"}, 32'(recv_rdy), 32'd1);
        a = x; b = y; recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        a = ~x; b = y + 8'd3;
        check({tag, "_busy"}, 32'(recv_rdy), 32'd0);
        lat = 0;
        while (!send_val && lat < 50) begin
            if (poke && lat == 3) begin
                recv_val = 1'b1; a = 8'h11; b = 8'h01;
            end else begin
                recv_val = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        recv_val = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd12);
        check({tag, "_c"}, 32'(c), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_c"}, 32'(c), 32'(exp));
            check({tag, "_hold_v"}, {30'd0, send_val, recv_rdy}, 32'd2);
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        check({tag, "_ack"}, {30'd0, send_val, recv_rdy}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", {22'd0, recv_rdy, send_val, c}, 32'h200);

        run(8'h18, 8'h08, 0, 1'b0, "basic");
        run(8'hF0, 8'h30, 0, 1'b0, "neg_trunc");
        run(8'h10, 8'h30, 0, 1'b0, "pos_trunc");
        run(8'hE8, 8'h08, 0, 1'b0, "neg_res");
        run(8'h10, 8'h00, 0, 1'b0, "dz_pos");
        run(8'hF0, 8'h00, 0, 1'b0, "dz_neg");
        run(8'h70, 8'h04, 0, 1'b0, "ovf");
        run(8'h80, 8'hFF, 0, 1'b0, "ovf_min");
        run(8'h30, 8'h18, 5, 1'b0, "backpr");
        run(8'hD8, 8'h14, 0, 1'b1, "poke");

        // Busy-time recv_val must not have queued a second job.
        repeat (3) begin
            @(posedge clk); #1;
            check("no_queue", {30'd0, send_val, recv_rdy}, 32'd1);
        end

        // Reset during CALC discards the job.
        a = 8'h18; b = 8'h08; recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_calc", {22'd0, recv_rdy, send_val, c}, 32'h200);
        run(8'h24, 8'hF8, 0, 1'b0, "after_rst");

        // Reset while holding a result in DONE.
        a = 8'h18; b = 8'h08; recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_done", {22'd0, recv_rdy, send_val, c}, 32'h200);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] rx;
            logic [7:0] ry;
            rx = 8'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run(rx, ry, int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
